// File: rtl/regfile_lanes.sv
// regfile_lanes: N-entry register file with lane writes, bypassed read ports,
// registered branch compare and a load busy scoreboard that drives stall.
module regfile_lanes #(
    parameter int DATA_W  = 16,
    parameter int NREGS   = 8,
    parameter int AW      = 4,
    parameter int LANE_W  = 4,
    parameter int ADR_IDX = 4,
    localparam int LANES  = DATA_W / LANE_W,
    localparam int LW     = LANES > 1 ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_full,
    input  logic [LW-1:0]     wr_lane,
    input  logic [AW-1:0]     rd_addr0,
    output logic [DATA_W-1:0] rd_data0,
    input  logic [AW-1:0]     rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic              imm_sel,
    input  logic              move,
    input  logic [AW-1:0]     mem_sel,
    output logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] address,
    input  logic [3:0]        cmp_op,
    output logic              taken,
    output logic              taken_valid,
    input  logic              busy_set,
    input  logic [AW-1:0]     busy_addr,
    output logic              stall
);
    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [DATA_W-1:0] cur, mask, lane_val, merged;
    logic              wr_hit, cmp_hit, cmp_res;

    function automatic logic [DATA_W-1:0] stored(input logic [AW-1:0] a);
        stored = '0;
        for (int i = 0; i < NREGS; i++)
            if (a == AW'(i)) stored = regs[i];
    endfunction

    function automatic logic [DATA_W-1:0] operand(input logic [AW-1:0] a);
        operand = (wr_hit && wr_addr == a) ? merged : stored(a);
    endfunction

    // a write landing this cycle satisfies the pending load, so it masks the busy bit
    function automatic logic waiting(input logic [AW-1:0] a);
        waiting = 1'b0;
        for (int i = 0; i < NREGS; i++)
            if (a == AW'(i)) waiting = busy[i] && !(wr_hit && wr_addr == a);
    endfunction

    always_comb begin
        wr_hit   = wr_en && int'(wr_addr) < NREGS;
        cur      = stored(wr_addr);
        mask     = DATA_W'({LANE_W{1'b1}}) << (int'(wr_lane) * LANE_W);
        lane_val = DATA_W'(wr_data[LANE_W-1:0]) << (int'(wr_lane) * LANE_W);
        merged   = wr_full ? wr_data : int'(wr_lane) < LANES ? (cur & ~mask) | lane_val : cur;
    end

    always_comb begin
        rd_data0 = imm_sel ? DATA_W'(rd_addr0) : operand(rd_addr0);
        rd_data1 = (imm_sel || move) ? '0 : operand(rd_addr1);
        mem_data = operand(mem_sel);
        address  = stored(AW'(ADR_IDX));
        stall    = (!imm_sel && waiting(rd_addr0)) || (!imm_sel && !move && waiting(rd_addr1));
        cmp_hit  = cmp_op >= 4'd4 && cmp_op <= 4'd8;
        cmp_res  = cmp_op == 4'd4 ? rd_data0 >= rd_data1 :
                   cmp_op == 4'd5 ? rd_data0[DATA_W-1] :
                   cmp_op == 4'd6 ? rd_data0 == '0 :
                   cmp_op == 4'd7 ? rd_data0 == rd_data1 :
                   rd_data0 != rd_data1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            busy        <= '0;
            taken       <= 1'b0;
            taken_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_hit && wr_addr == AW'(i)) regs[i] <= merged;
                if (busy_set && busy_addr == AW'(i)) busy[i] <= 1'b1;
                else if (wr_hit && wr_addr == AW'(i)) busy[i] <= 1'b0;
            end
            taken_valid <= cmp_hit;
            if (cmp_hit) taken <= cmp_res;
        end
    end
endmodule

// File: tb/tb_regfile_lanes.sv
// tb_regfile_lanes: directed vector table plus randomized run checked against
// an array-based reference model of the register file.
module tb_regfile_lanes;
    logic        clk = 0, rst_n = 0;
    logic        wr_en = 0, wr_full = 0, imm_sel = 0, move = 0, busy_set = 0;
    logic [3:0]  wr_addr = 0, rd_addr0 = 0, rd_addr1 = 0, mem_sel = 0, cmp_op = 0, busy_addr = 0;
    logic [1:0]  wr_lane = 0;
    logic [15:0] wr_data = 0;
    logic [15:0] rd_data0, rd_data1, mem_data, address;
    logic        taken, taken_valid, stall;
    int          errors = 0, checks = 0;

    regfile_lanes dut (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_full(wr_full), .wr_lane(wr_lane), .rd_addr0(rd_addr0), .rd_data0(rd_data0),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1), .imm_sel(imm_sel), .move(move),
        .mem_sel(mem_sel), .mem_data(mem_data), .address(address), .cmp_op(cmp_op),
        .taken(taken), .taken_valid(taken_valid), .busy_set(busy_set), .busy_addr(busy_addr),
        .stall(stall));

    always #5 clk = ~clk;

    typedef struct {
        bit we; bit [3:0] wa; bit [15:0] wd; bit wf; bit [1:0] wl;
        bit [3:0] a0, a1; bit imm, mv; bit [3:0] ms, op; bit bs; bit [3:0] ba;
        bit [15:0] e0, e1, em; bit es, et, ev;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t v(bit we, bit [3:0] wa, bit [15:0] wd, bit wf, bit [1:0] wl,
        bit [3:0] a0, bit [3:0] a1, bit imm, bit mv, bit [3:0] ms, bit [3:0] op, bit bs, bit [3:0] ba,
        bit [15:0] e0, bit [15:0] e1, bit [15:0] em, bit es, bit et, bit ev);
        vec_t r;
        r.we = we; r.wa = wa; r.wd = wd; r.wf = wf; r.wl = wl; r.a0 = a0; r.a1 = a1;
        r.imm = imm; r.mv = mv; r.ms = ms; r.op = op; r.bs = bs; r.ba = ba;
        r.e0 = e0; r.e1 = e1; r.em = em; r.es = es; r.et = et; r.ev = ev;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        wr_en = r.we; wr_addr = r.wa; wr_data = r.wd; wr_full = r.wf; wr_lane = r.wl;
        rd_addr0 = r.a0; rd_addr1 = r.a1; imm_sel = r.imm; move = r.mv; mem_sel = r.ms;
        cmp_op = r.op; busy_set = r.bs; busy_addr = r.ba;
    endtask

    // reference model: plain arrays and integer lane arithmetic
    logic [15:0] mr [8];
    bit          mb [8];
    bit          mt;

    function automatic logic [15:0] model_merge(logic [15:0] old);
        int unit = 1 << (4 * int'(wr_lane));
        int o = old;
        if (wr_full) return wr_data;
        return 16'(o - ((o / unit) % 16) * unit + (int'(wr_data) % 16) * unit);
    endfunction

    function automatic logic [15:0] model_op(logic [3:0] a);
        if (a >= 8) return 0;
        if (wr_en && wr_addr == a) return model_merge(mr[a]);
        return mr[a];
    endfunction

    function automatic bit model_busy(logic [3:0] a);
        return a < 8 && mb[a] && !(wr_en && wr_addr == a);
    endfunction

    initial begin
        vec_t r;
        logic [15:0] x0, x1;
        bit xs, xv;
        //     we wa wd      wf wl a0 a1 im mv ms op bs ba  e0       e1       em       es et ev
        vecs.push_back(v(1, 2, 16'hBEEF, 1, 0, 2, 0, 0, 0, 2, 0, 0, 0, 16'hBEEF, 16'h0, 16'hBEEF, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'h0, 1, 0, 2, 2, 0, 0, 0, 7, 0, 0, 16'hBEEF, 16'hBEEF, 16'h0, 0, 1, 1));
        vecs.push_back(v(1, 5, 16'h1234, 1, 0, 5, 2, 0, 0, 5, 4, 0, 0, 16'h1234, 16'hBEEF, 16'h1234, 0, 0, 1));
        vecs.push_back(v(1, 5, 16'hFFFA, 0, 2, 5, 5, 0, 0, 5, 0, 0, 0, 16'h1A34, 16'h1A34, 16'h1A34, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'h0, 0, 0, 7, 3, 1, 0, 2, 6, 0, 0, 16'h0007, 16'h0, 16'hBEEF, 0, 0, 1));
        vecs.push_back(v(0, 0, 16'h0, 0, 0, 5, 2, 0, 1, 5, 8, 0, 0, 16'h1A34, 16'h0, 16'h1A34, 0, 1, 1));
        vecs.push_back(v(1, 0, 16'h8000, 1, 0, 0, 0, 0, 0, 0, 5, 0, 0, 16'h8000, 16'h8000, 16'h8000, 0, 1, 1));
        vecs.push_back(v(1, 1, 16'h0003, 1, 0, 1, 0, 0, 0, 1, 4, 0, 0, 16'h0003, 16'h8000, 16'h0003, 0, 0, 1));
        vecs.push_back(v(0, 0, 16'h0, 1, 0, 0, 1, 0, 0, 2, 0, 0, 0, 16'h8000, 16'h0003, 16'hBEEF, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'h0, 1, 0, 0, 1, 0, 0, 5, 5, 0, 0, 16'h8000, 16'h0003, 16'h1A34, 0, 1, 1));
        vecs.push_back(v(0, 0, 16'h0, 1, 0, 0, 1, 0, 0, 5, 0, 0, 0, 16'h8000, 16'h0003, 16'h1A34, 0, 1, 0));
        vecs.push_back(v(0, 0, 16'h0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 3, 16'h8000, 16'h0003, 16'h8000, 0, 1, 0));
        vecs.push_back(v(0, 0, 16'h0, 1, 0, 3, 1, 0, 0, 3, 0, 0, 0, 16'h0, 16'h0003, 16'h0, 1, 1, 0));
        vecs.push_back(v(1, 3, 16'h0055, 1, 0, 3, 1, 0, 0, 3, 0, 0, 0, 16'h0055, 16'h0003, 16'h0055, 0, 1, 0));
        vecs.push_back(v(0, 0, 16'h0, 1, 0, 3, 1, 0, 0, 3, 0, 0, 0, 16'h0055, 16'h0003, 16'h0055, 0, 1, 0));
        vecs.push_back(v(1, 3, 16'h0066, 1, 0, 3, 1, 0, 0, 3, 0, 1, 3, 16'h0066, 16'h0003, 16'h0066, 0, 1, 0));
        vecs.push_back(v(0, 0, 16'h0, 1, 0, 3, 1, 0, 0, 3, 0, 0, 0, 16'h0066, 16'h0003, 16'h0066, 1, 1, 0));
        vecs.push_back(v(0, 0, 16'h0, 1, 0, 0, 3, 0, 1, 3, 0, 0, 0, 16'h8000, 16'h0, 16'h0066, 0, 1, 0));
        vecs.push_back(v(0, 0, 16'h0, 1, 0, 0, 3, 0, 0, 3, 0, 0, 0, 16'h8000, 16'h0066, 16'h0066, 1, 1, 0));
        vecs.push_back(v(1, 12, 16'hFFFF, 1, 0, 12, 1, 0, 0, 12, 0, 1, 12, 16'h0, 16'h0003, 16'h0, 0, 1, 0));
        vecs.push_back(v(0, 0, 16'h0, 1, 0, 1, 4, 0, 0, 4, 0, 0, 0, 16'h0003, 16'h0, 16'h0, 0, 1, 0));
        vecs.push_back(v(1, 3, 16'h0077, 1, 0, 3, 4, 0, 0, 4, 0, 0, 0, 16'h0077, 16'h0, 16'h0, 0, 1, 0));
        vecs.push_back(v(0, 0, 16'h0, 1, 0, 3, 4, 0, 0, 4, 0, 0, 0, 16'h0077, 16'h0, 16'h0, 0, 1, 0));

        rd_addr0 = 2;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd_data0", rd_data0, 16'h0);
        chk("reset taken", taken, 1'b0);
        chk("reset taken_valid", taken_valid, 1'b0);
        chk("reset stall", stall, 1'b0);
        rst_n = 1;
        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            #2;
            chk($sformatf("v%0d rd_data0", i), rd_data0, vecs[i].e0);
            chk($sformatf("v%0d rd_data1", i), rd_data1, vecs[i].e1);
            chk($sformatf("v%0d mem_data", i), mem_data, vecs[i].em);
            chk($sformatf("v%0d stall", i), stall, vecs[i].es);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d taken", i), taken, vecs[i].et);
            chk($sformatf("v%0d taken_valid", i), taken_valid, vecs[i].ev);
        end

        // asynchronous reset mid-run: state clears with no clock edge
        r = v(0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(r);
        #1;
        chk("pre-reset r3", rd_data0, 16'h0077);
        rst_n = 0;
        #1;
        chk("async reset rd_data0", rd_data0, 16'h0);
        chk("async reset taken", taken, 1'b0);
        chk("async reset address", address, 16'h0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin mr[i] = 0; mb[i] = 0; end
        mt = 0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 400; n++) begin
            wr_en = $urandom_range(0, 1); wr_addr = 4'($urandom_range(0, 11));
            wr_data = 16'($urandom); wr_full = $urandom_range(0, 1); wr_lane = 2'($urandom_range(0, 3));
            rd_addr0 = 4'($urandom_range(0, 11)); rd_addr1 = 4'($urandom_range(0, 11));
            mem_sel = 4'($urandom_range(0, 11)); imm_sel = $urandom_range(0, 7) == 0;
            move = $urandom_range(0, 5) == 0; cmp_op = 4'($urandom_range(0, 15));
            busy_set = $urandom_range(0, 3) == 0; busy_addr = 4'($urandom_range(0, 11));
            #2;
            x0 = imm_sel ? 16'(rd_addr0) : model_op(rd_addr0);
            x1 = (imm_sel || move) ? 16'h0 : model_op(rd_addr1);
            xs = (!imm_sel && model_busy(rd_addr0)) || (!imm_sel && !move && model_busy(rd_addr1));
            chk("rand rd_data0", rd_data0, x0);
            chk("rand rd_data1", rd_data1, x1);
            chk("rand mem_data", mem_data, model_op(mem_sel));
            chk("rand address", address, mr[4]);
            chk("rand stall", stall, xs);
            xv = cmp_op >= 4 && cmp_op <= 8;
            case (cmp_op)
                4: mt = x0 >= x1;
                5: mt = x0 >= 16'h8000;
                6: mt = x0 == 0;
                7: mt = x0 == x1;
                8: mt = x0 != x1;
                default: ;
            endcase
            if (wr_en && wr_addr < 8) begin
                mr[wr_addr] = model_merge(mr[wr_addr]);
                mb[wr_addr] = 0;
            end
            if (busy_set && busy_addr < 8) mb[busy_addr] = 1;
            @(posedge clk);
            #1;
            chk("rand taken", taken, mt);
            chk("rand taken_valid", taken_valid, xv);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_lanes.md
Name: regfile_lanes

Overview:
- Parametrised successor to the 16-bit, 8-entry CPU register file. Sits in the decode stage of the pipelined CPU.
- Provides N general registers with full-word or lane-granular writes.
- Write-to-read bypass on both read ports and an immediate/move operand mux.
- Registered branch-compare unit producing a `taken` flag with a valid strobe.
- Per-register busy scoreboard that raises `stall` when an operand is awaiting a pending load.

Parameters:
- DATA_W, 16: register width in bits.
- NREGS, 8: number of registers; must be ≤ 2**AW.
- AW, 4: register address width.
- LANE_W, 4: partial-write lane width; DATA_W must be a multiple of LANE_W.
- ADR_IDX, 4: index of the register driven on `address`.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- wr_en, in, 1: write enable.
- wr_addr, in, AW: write register index.
- wr_data, in, DATA_W: write data. For a lane write, only the low LANE_W bits are used.
- wr_full, in, 1: 1 = full-word write; 0 = lane write.
- wr_lane, in, clog2(DATA_W/LANE_W): target lane for a lane write.
- rd_addr0, in, AW: operand-0 index; also the immediate value when imm_sel=1.
- rd_data0, out, DATA_W: operand 0.
- rd_addr1, in, AW: operand-1 index.
- rd_data1, out, DATA_W: operand 1.
- imm_sel, in, 1: immediate mode.
- move, in, 1: move mode; forces operand 1 to zero.
- mem_sel, in, AW: register index for store data.
- mem_data, out, DATA_W: store data.
- address, out, DATA_W: current contents of register ADR_IDX.
- cmp_op, in, 4: compare opcode.
- taken, out, 1: registered compare result.
- taken_valid, out, 1: one-cycle strobe, high when `taken` was updated.
- busy_set, in, 1: a load has been issued to busy_addr.
- busy_addr, in, AW: destination register of that load.
- stall, out, 1: an operand is busy.

Behaviour:
- Reset (async, rst_n=0): all registers 0, all busy bits 0, taken=0, taken_valid=0. Reset mid-operation discards any pending write or compare.
- Write, on the rising edge with wr_en=1 and wr_addr<NREGS:
  - wr_full=1: reg ← wr_data.
  - wr_full=0: bits [wr_lane*LANE_W +: LANE_W] ← wr_data[LANE_W-1:0]; all other bits hold.
  - Ignored if wr_addr≥NREGS, or if wr_lane≥DATA_W/LANE_W on a lane write.
- Merged value: the post-write register value, i.e. the lane merge applied to the current contents.
- rd_data0, combinational:
  - imm_sel=1: zero-extended rd_addr0.
  - else rd_addr0≥NREGS: 0.
  - else bypass hit (wr_en and wr_addr==rd_addr0): merged value.
  - else the stored register.
- rd_data1, combinational: 0 if imm_sel or move; otherwise the same out-of-range, bypass and stored-register rules as port 0, using rd_addr1.
- mem_data: the mem_sel register, with the same bypass and out-of-range rules.
- address: stored value of ADR_IDX only; no bypass.
- Compare: opcode sampled on the clock edge using the bypassed rd_data0/rd_data1. Latency is 1 cycle.
  - 4 GTE: unsigned rd_data0 ≥ rd_data1.
  - 5 LTZ: rd_data0[DATA_W-1].
  - 6 EZ: rd_data0 == 0.
  - 7 EQ: rd_data0 == rd_data1.
  - 8 NE: rd_data0 != rd_data1.
  - For opcodes 4–8, `taken` is updated and taken_valid=1 for the next cycle.
  - Any other opcode: `taken` holds and taken_valid=0.
- Scoreboard, updated on the clock edge:
  - busy_set sets busy[busy_addr]; ignored if busy_addr≥NREGS.
  - A write (wr_en with in-range wr_addr) clears busy[wr_addr].
  - Set and clear to the same address in the same cycle: set wins, because a new load has been issued.
- stall, combinational: (busy[rd_addr0] & ~imm_sel) | (busy[rd_addr1] & ~imm_sel & ~move).
  - An out-of-range address never contributes to stall.
  - A bypass hit on an operand's register suppresses that operand's stall term, because the data is arriving this cycle.

Test Plan:
- Reset, then full write 0xBEEF to r2; next cycle rd_addr0=2 → rd_data0=0xBEEF. Assert rst_n=0 mid-run → rd_data0=0 immediately, with no clock edge.
- r5=0x1234; lane write, lane 2, data 0xA → r5=0x1A34. In the same cycle as the write, rd_addr1=5 → bypassed rd_data1=0x1A34.
- imm_sel=1, rd_addr0=7, rd_addr1=3 → rd_data0=0x0007, rd_data1=0. move=1 alone → rd_data1=0.
- r0=0x8000, r1=3:
  - cmp_op=5 (LTZ) on r0 → taken=1 one cycle later, taken_valid pulses once.
  - cmp_op=4 (GTE), operands r1,r0 → taken=0 (unsigned compare).
  - cmp_op=0 → taken holds, taken_valid=0.
- busy_set for r3 → next cycle rd_addr0=3 gives stall=1. Write r3 → stall drops in the same cycle via bypass, and the busy bit is clear afterwards. Set and write r3 in the same cycle → busy stays 1.
- Out-of-range: write wr_addr=12 with NREGS=8 → no register changes. rd_addr0=12 → rd_data0=0 and stall=0.
